// File: rtl/lfsr_rng_pkg.sv
// Shared types and constants for the LFSR random-sample stream.
// FSM state encoding and the default feedback tap mask.
package lfsr_rng_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FULL  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // x^31 + x^28 + 1: taps on state bits 30 and 27
    localparam logic [30:0] DEFAULT_TAP_MASK = 31'h4800_0000;

endpackage

// File: rtl/rng_sync_fifo.sv
// Synchronous FIFO buffering accepted samples for the consumer.
// Head entry is visible combinationally from registered storage.
module rng_sync_fifo
    import lfsr_rng_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [LW-1:0]    r_level;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_level == LW'(DEPTH));
    assign empty  = (r_level == '0);
    assign level  = r_level;
    assign dout   = r_mem[r_rd];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Pointer and occupancy bookkeeping; flush empties the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else if (flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Sample storage; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (w_push && !flush) r_mem[r_wr] <= din;
    end

endmodule

// File: rtl/lfsr_rng_stream.sv
// Fibonacci LFSR producing range-filtered samples into a small FIFO.
// Optional LFSR_RNG_STREAM_LOCKUP_RECOVER_EN reloads SEED on an all-zero state.
module lfsr_rng_stream
    import lfsr_rng_pkg::*;
#(
    parameter int                        INTERNAL_WIDTH = 31,
    parameter logic [INTERNAL_WIDTH-1:0] TAP_MASK       =
        INTERNAL_WIDTH'(DEFAULT_TAP_MASK),
    parameter int                        OUT_WIDTH      = 9,
    parameter int unsigned               OUT_MIN        = 1,
    parameter int unsigned               OUT_MAX        = 479,
    parameter int                        FIFO_DEPTH     = 4,
    parameter logic [INTERNAL_WIDTH-1:0] SEED           = '1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ce,
    input  logic                          seed_valid,
    input  logic [INTERNAL_WIDTH-1:0]     seed,
    output logic [OUT_WIDTH-1:0]          out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam logic [OUT_WIDTH-1:0] MIN_V = OUT_WIDTH'(OUT_MIN);
    localparam logic [OUT_WIDTH-1:0] MAX_V = OUT_WIDTH'(OUT_MAX);

    state_t                    r_state;
    state_t                    w_state_nx;
    logic [INTERNAL_WIDTH-1:0] r_internal;
    logic [INTERNAL_WIDTH-1:0] w_shift;
    logic [OUT_WIDTH-1:0]      w_cand;
    logic [OUT_WIDTH-1:0]      w_dout;
    logic                      w_fb;
    logic                      w_in_range;
    logic                      w_adv;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_full;
    logic                      w_empty;
`ifdef LFSR_RNG_STREAM_LOCKUP_RECOVER_EN
    logic                      w_zero;

    assign w_zero = (r_internal == '0);
`endif

    assign w_fb       = ^(r_internal & TAP_MASK);
    assign w_shift    = {r_internal[INTERNAL_WIDTH-2:0], w_fb};
    assign w_cand     = r_internal[OUT_WIDTH-1:0];
    assign w_in_range = (w_cand >= MIN_V) && (w_cand <= MAX_V);

    assign out_valid  = !w_empty;
    assign out        = w_empty ? MIN_V : w_dout;
    assign w_pop      = out_valid && out_ready && !seed_valid;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_state_nx;
    end

    // Next state: seed load wins, FULL tracks the registered level.
    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            RUN:     if (w_full)  w_state_nx = FULL;
            FULL:    if (!w_full) w_state_nx = RUN;
            FLUSH:   w_state_nx = RUN;
            default: w_state_nx = RUN;
        endcase
        if (seed_valid) w_state_nx = FLUSH;
    end

    // Advance only in RUN with room; push only in-range candidates.
    always_comb begin
        w_adv  = 1'b0;
        w_push = 1'b0;
        if (r_state == RUN && ce && !w_full && !seed_valid) begin
            w_adv  = 1'b1;
            w_push = w_in_range;
`ifdef LFSR_RNG_STREAM_LOCKUP_RECOVER_EN
            if (w_zero) w_push = 1'b0;
`endif
        end
    end

    // LFSR state: seed load, then shift (or lockup reload) on advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_internal <= SEED;
        end else if (seed_valid) begin
            r_internal <= (seed == '0) ? SEED : seed;
        end else if (w_adv) begin
`ifdef LFSR_RNG_STREAM_LOCKUP_RECOVER_EN
            r_internal <= w_zero ? SEED : w_shift;
`else
            r_internal <= w_shift;
`endif
        end
    end

    rng_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (OUT_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (seed_valid),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_cand),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .level (level)
    );

endmodule

// File: tb/tb_lfsr_rng_stream.sv
// Randomized bench for lfsr_rng_stream against a queue-based model.
// Default build only (lockup recovery disabled).
module tb_lfsr_rng_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        seed_valid;
    logic [30:0] seed;
    logic [8:0]  out;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  level;

    int n_chk  = 0;
    int n_pass = 0;

    int          q[$];
    logic [30:0] m_lf;
    int          m_st;
    logic [30:0] saved_lf;

    always #5 clk = ~clk;

    lfsr_rng_stream dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .seed_valid (seed_valid),
        .seed       (seed),
        .out        (out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .level      (level)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic m_reset();
        m_lf = '1;
        q.delete();
        m_st = 0;
    endtask

    task automatic m_edge();
        int sz;
        int cand;
        bit push;
        bit pop;
        sz   = q.size();
        cand = 0;
        push = 0;
        if (seed_valid) begin
            m_lf = (seed == 0) ? '1 : seed;
            q.delete();
            m_st = 2;
        end else begin
            pop = (sz > 0) && out_ready;
            if (m_st == 0 && ce && sz < 4) begin
                cand = int'(m_lf % 512);
                m_lf = {m_lf[29:0], m_lf[30] ^ m_lf[27]};
                push = (cand >= 1) && (cand <= 479);
            end
            case (m_st)
                0:       if (sz == 4) m_st = 1;
                1:       if (sz < 4)  m_st = 0;
                default: m_st = 0;
            endcase
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(cand);
        end
    endtask

    task automatic compare();
        chk("level", level, q.size());
        chk("valid", out_valid, q.size() != 0);
        chk("out", out, (q.size() != 0) ? q[0] : 1);
        chk("lfsr", dut.r_internal, m_lf);
        chk("state", dut.r_state, m_st);
    endtask

    task automatic step();
        @(posedge clk);
        m_edge();
        #1;
        compare();
    endtask

    initial begin
        rst        = 1'b1;
        ce         = 1'b0;
        seed_valid = 1'b0;
        seed       = '0;
        out_ready  = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        compare();
        chk("rst_out", out, 1);
        rst = 1'b0;

        // first accepted sample after six rejections
        ce        = 1'b1;
        out_ready = 1'b1;
        repeat (6) step();
        chk("none_yet", out_valid, 0);
        step();
        chk("first_out", out, 448);
        chk("first_vld", out_valid, 1);

        // fill up and freeze
        out_ready = 1'b0;
        repeat (30) step();
        chk("full_lvl", level, 4);
        chk("full_st", dut.r_state, 1);
        saved_lf = m_lf;
        repeat (10) step();
        chk("frozen", dut.r_internal, saved_lf);

        // single pop from FULL
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("pop_lvl", level, 3);
        chk("pop_st", dut.r_state, 1);
        chk("pop_lf", dut.r_internal, saved_lf);
        step();
        chk("ret_run", dut.r_state, 0);
        chk("no_push", level, 3);

        // random traffic with occasional reseeds
        for (int i = 0; i < 400; i++) begin
            ce         = ($urandom_range(0, 3) != 0);
            out_ready  = $urandom_range(0, 1) == 1;
            seed_valid = ($urandom_range(0, 40) == 0);
            seed       = ($urandom_range(0, 3) == 0) ? '0 : 31'($urandom);
            step();
        end
        seed_valid = 1'b0;

        // zero-seed load while level is 2
        seed_valid = 1'b1;
        seed       = '0;
        out_ready  = 1'b0;
        ce         = 1'b1;
        step();
        seed_valid = 1'b0;
        for (int i = 0; i < 40 && q.size() != 2; i++) step();
        chk("reach_lvl2", level, 2);
        seed_valid = 1'b1;
        seed       = '0;
        step();
        seed_valid = 1'b0;
        ce         = 1'b0;
        chk("flush_st", dut.r_state, 2);
        chk("flush_lvl", level, 0);
        chk("flush_vld", out_valid, 0);
        chk("flush_lf", dut.r_internal, 31'h7fff_ffff);
        step();
        chk("flush_run", dut.r_state, 0);

        // asynchronous reset mid-operation at level 3
        ce = 1'b1;
        for (int i = 0; i < 40 && q.size() != 3; i++) step();
        chk("reach_lvl3", level, 3);
        ce = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_vld", out_valid, 0);
        chk("arst_lvl", level, 0);
        chk("arst_out", out, 1);
        m_reset();
        compare();
        @(negedge clk);
        rst = 1'b0;
        ce  = 1'b1;
        out_ready = 1'b1;
        repeat (7) step();
        chk("post_rst_out", out, 448);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lfsr_rng_stream.md
LFSR_RNG_STREAM -- requirements
Module: lfsr_rng_stream

Interface
REQ-001 SHALL have parameter INTERNAL_WIDTH, default 31, LFSR state width.
REQ-002 SHALL have parameter TAP_MASK, default bits 30 and 27 set, feedback tap mask of width INTERNAL_WIDTH.
REQ-003 SHALL have parameter OUT_WIDTH, default 9, output sample width; must be at most INTERNAL_WIDTH.
REQ-004 SHALL have parameters OUT_MIN, default 1, and OUT_MAX, default 479, the inclusive accept range; OUT_MIN must be at most OUT_MAX.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries; must be a power of two and at least 2.
REQ-006 SHALL have parameter SEED, default all ones, reset and fallback LFSR state; must be nonzero.
REQ-007 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-008 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-009 Port ce, input, 1 bit: advance enable.
REQ-010 Port seed_valid, input, 1 bit: load seed this cycle.
REQ-011 Port seed, input, INTERNAL_WIDTH bits: new LFSR state.
REQ-012 Port out, output, OUT_WIDTH bits: FIFO head sample.
REQ-013 Port out_valid, output, 1 bit: FIFO not empty.
REQ-014 Port out_ready, input, 1 bit: consumer accepts; a pop occurs when out_valid and out_ready are both high.
REQ-015 Port level, output, log2(FIFO_DEPTH)+1 bits: FIFO occupancy.

Function
REQ-016 FSM states SHALL be RUN, FULL and FLUSH.
REQ-017 In RUN with ce high, each cycle SHALL take candidate = internal[OUT_WIDTH-1:0], then shift internal left by one, with bit 0 = XOR-reduce(internal AND TAP_MASK).
REQ-018 A candidate SHALL be pushed into the FIFO only if OUT_MIN <= candidate <= OUT_MAX (unsigned); otherwise it SHALL be discarded with no push.
REQ-019 With ce low, internal and push SHALL hold; pops SHALL continue.
REQ-020 Push-to-visibility latency SHALL be 1 cycle: a candidate accepted at edge N appears on out/out_valid after edge N when the FIFO was empty.
REQ-021 FULL SHALL be entered when the registered level equals FIFO_DEPTH; in FULL the LFSR SHALL not advance and no push SHALL occur, even if a pop happens in the same cycle.
REQ-022 The FSM SHALL return from FULL to RUN on the edge after level drops below FIFO_DEPTH.
REQ-023 No combinational path SHALL exist from out_ready to any output.
REQ-024 A simultaneous push and pop in RUN SHALL leave level unchanged; out SHALL advance to the next entry.
REQ-025 seed_valid (priority over ce and pop) SHALL load internal = seed, or SEED if seed is 0, empty the FIFO, and enter FLUSH.
REQ-026 FLUSH SHALL last exactly one cycle with out_valid low and no advance, then enter RUN.
REQ-027 out SHALL be driven to OUT_MIN whenever out_valid is low.
REQ-028 level SHALL never exceed FIFO_DEPTH or underflow below 0.

Reset
REQ-029 rst SHALL asynchronously force internal = SEED, FIFO empty, level = 0, out_valid = 0, out = OUT_MIN, state = RUN.
REQ-030 rst asserted mid-operation SHALL discard all buffered samples and any seed load in progress.

Configuration
REQ-031 With LFSR_RNG_STREAM_LOCKUP_RECOVER_EN defined, if internal becomes all zeros in RUN it SHALL be reloaded with SEED on the next edge in place of a shift, with no push that cycle.
REQ-032 Without LFSR_RNG_STREAM_LOCKUP_RECOVER_EN, no zero detection logic SHALL exist and an all-zero state SHALL persist.

Structure
REQ-033 A shared package lfsr_rng_pkg SHALL hold the FSM state enum (RUN, FULL, FLUSH) and the default tap-mask constant.
REQ-034 The FIFO SHALL be a sub-module rng_sync_fifo with FIFO_DEPTH and OUT_WIDTH parameters, exposing push, pop, full, empty and level.

Verification
REQ-035 Reset with defaults, then ce=1 and out_ready=1: candidates 511, 510, 508, 504, 496 and 480 are rejected, and the first out value is 448 with out_valid high after the 7th edge.
REQ-036 Hold out_ready=0 with ce=1: level reaches 4, the FSM is in FULL, and internal stays frozen over 10 cycles.
REQ-037 With FIFO full, pulse out_ready for 1 cycle: level goes 4 to 3, the FSM returns to RUN after one edge, and no push occurs in the pop cycle.
REQ-038 Assert seed_valid with seed=0 while level=2: the next state is FLUSH with level=0, out_valid=0 and internal equal to SEED, followed by RUN.
REQ-039 Assert rst asynchronously between edges with level=3: out_valid=0, level=0 and out=1 immediately, with no clock edge needed.
REQ-040 With LFSR_RNG_STREAM_LOCKUP_RECOVER_EN defined, seed internal via a forced all-zero state: the next edge reloads all ones and sampling resumes.
